// File: rtl/ag6502_vic_pkg.sv
// Shared definitions for the ag6502 vectored interrupt controller:
// register indices, FSM states, CPU vector addresses and the ISR address helper.
package ag6502_vic_pkg;

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_MODE    = 3'd2;
    localparam logic [2:0] REG_ACTIVE  = 3'd3;
    localparam logic [2:0] REG_FORCE   = 3'd4;
    localparam logic [2:0] REG_PRIO_LO = 3'd5;
    localparam logic [2:0] REG_PRIO_HI = 3'd6;

    localparam logic [15:0] VEC_LO_ADDR = 16'hFFFE;
    localparam logic [15:0] VEC_HI_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } vic_state_e;

    // ISR entry of a channel; the sum wraps at 16 bits like the CPU address space.
    function automatic logic [15:0] isr_addr(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input logic [2:0]  ch);
        isr_addr = base + 16'(stride * {13'd0, ch});
    endfunction

endpackage

// File: rtl/ag6502_vic_arb.sv
// Combinational arbiter: picks the highest 2-bit priority among requesting
// channels; equal priorities resolve to the lowest index.
module ag6502_vic_arb #(
    parameter int NCH = 8
) (
    input  logic [7:0]  req,
    input  logic [15:0] prio,
    output logic        valid,
    output logic [2:0]  chan
);
    logic [1:0] best_s;
    logic       take_s;

    // Scan upward; a later channel only wins with strictly higher priority.
    always_comb begin
        valid  = 1'b0;
        chan   = 3'd0;
        best_s = 2'd0;
        take_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            take_s = req[i] & (~valid | (prio[2*i +: 2] > best_s));
            valid  = valid | take_s;
            chan   = take_s ? 3'(i) : chan;
            best_s = take_s ? prio[2*i +: 2] : best_s;
        end
    end

endmodule

// File: rtl/ag6502_vic.sv
// ag6502 vectored interrupt controller: request capture, irq generation and
// vector substitution at $FFFE/$FFFF. Per-channel priority with AG6502_VIC_PRIO_EN.
module ag6502_vic
    import ag6502_vic_pkg::*;
#(
    parameter int          NCH        = 8,
    parameter logic [15:0] VEC_BASE   = 16'hF800,
    parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
    input  logic           phi_0,
    input  logic           rst,
    input  logic [NCH-1:0] irq_in,
    input  logic           cyc,
    input  logic [15:0]    ab,
    input  logic           read,
    input  logic           cs,
    input  logic [2:0]     addr,
    input  logic [7:0]     wdata,
    output logic [7:0]     rdata,
    output logic           irq,
    output logic           vec_ovr,
    output logic [7:0]     vec_data
);
    localparam logic [8:0] CH_MASK9 = (9'd1 << NCH) - 9'd1;
    localparam logic [7:0] CH_MASK  = CH_MASK9[7:0];

    logic [7:0]  enable_r, mode_r, latch_r, prev_r;
    logic        irq_r, busy_r;
    logic [2:0]  chan_r;
    vic_state_e  state_r, state_n;

    logic [7:0]  irq_ext_s, pend_view_s, req_s, set_s, clr_s, latch_n_s;
    logic        wr_s, ack_s, take_s, arb_valid_s;
    logic [2:0]  arb_chan_s;
    logic [15:0] prio_s, isr_s;

    // Widen requests to the byte-wide register layout.
    always_comb begin
        irq_ext_s = 8'h00;
        irq_ext_s[NCH-1:0] = irq_in;
    end

    assign wr_s        = cyc & cs & ~read;
    // Level channels are a live view of irq_in; latch_r holds edge and FORCE bits.
    assign pend_view_s = (latch_r | (irq_ext_s & ~mode_r)) & CH_MASK;
    assign req_s       = pend_view_s & enable_r;
    assign set_s       = ((irq_ext_s & ~prev_r & mode_r)
                         | ((wr_s && addr == REG_FORCE) ? wdata : 8'h00)) & CH_MASK;
    assign clr_s       = ((wr_s && addr == REG_PENDING) ? wdata : 8'h00)
                         | (ack_s ? (8'h01 << chan_r) : 8'h00);
    assign latch_n_s   = ((latch_r & ~clr_s) | set_s) & CH_MASK;

`ifdef AG6502_VIC_PRIO_EN
    localparam logic [31:0] PRIO_MASK32 = (32'd1 << (2 * NCH)) - 32'd1;
    localparam logic [15:0] PRIO_MASK   = PRIO_MASK32[15:0];
    logic [15:0] prio_r;

    // Priority registers, two bits per channel.
    always_ff @(posedge phi_0 or posedge rst) begin
        if (rst) begin
            prio_r <= 16'h0000;
        end else if (wr_s && addr == REG_PRIO_LO) begin
            prio_r <= {prio_r[15:8], wdata} & PRIO_MASK;
        end else if (wr_s && addr == REG_PRIO_HI) begin
            prio_r <= {wdata, prio_r[7:0]} & PRIO_MASK;
        end else begin
            prio_r <= prio_r;
        end
    end
    assign prio_s = prio_r;
`else
    assign prio_s = 16'h0000;
`endif

    ag6502_vic_arb #(.NCH(NCH)) u_arb (
        .req   (req_s),
        .prio  (prio_s),
        .valid (arb_valid_s),
        .chan  (arb_chan_s)
    );

    // Control registers, pending latches, edge history and registered irq.
    always_ff @(posedge phi_0 or posedge rst) begin
        if (rst) begin
            enable_r <= 8'h00;
            mode_r   <= 8'h00;
            latch_r  <= 8'h00;
            prev_r   <= 8'h00;
            irq_r    <= 1'b1;
        end else begin
            if (wr_s && addr == REG_ENABLE) enable_r <= wdata & CH_MASK;
            else                            enable_r <= enable_r;
            if (wr_s && addr == REG_MODE)   mode_r   <= wdata & CH_MASK;
            else                            mode_r   <= mode_r;
            latch_r <= latch_n_s;
            prev_r  <= irq_ext_s;
            irq_r   <= ~|req_s;
        end
    end

    assign irq = irq_r;

    // Vector fetch tracker: IDLE -> LO on $FFFE, ack on $FFFF, any other cycle aborts.
    always_comb begin
        state_n = state_r;
        ack_s   = 1'b0;
        take_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cyc && read && ab == VEC_LO_ADDR && !irq_r && arb_valid_s) begin
                    take_s  = 1'b1;
                    state_n = ST_LO;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LO: begin
                if (cyc && read && ab == VEC_HI_ADDR) begin
                    ack_s   = 1'b1;
                    state_n = ST_HI;
                end else if (cyc) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_LO;
                end
            end
            ST_HI:   state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM state, latched channel and busy flag.
    always_ff @(posedge phi_0 or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            chan_r  <= 3'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            chan_r  <= take_s ? arb_chan_s : chan_r;
            busy_r  <= (state_n != ST_IDLE);
        end
    end

    assign isr_s = isr_addr(VEC_BASE, VEC_STRIDE, chan_r);

    // Override only while the CPU addresses the byte this state owns.
    always_comb begin
        vec_ovr  = 1'b0;
        vec_data = 8'h00;
        if (state_r == ST_LO && ab == VEC_LO_ADDR) begin
            vec_ovr  = 1'b1;
            vec_data = isr_s[7:0];
        end else if (state_r == ST_HI && ab == VEC_HI_ADDR) begin
            vec_ovr  = 1'b1;
            vec_data = isr_s[15:8];
        end else begin
            vec_ovr  = 1'b0;
            vec_data = 8'h00;
        end
    end

    // Register read mux; reads have no side effects.
    always_comb begin
        rdata = 8'h00;
        case (addr)
            REG_ENABLE:  rdata = enable_r;
            REG_PENDING: rdata = pend_view_s;
            REG_MODE:    rdata = mode_r;
            REG_ACTIVE:  rdata = {busy_r, 4'b0000, chan_r};
`ifdef AG6502_VIC_PRIO_EN
            REG_PRIO_LO: rdata = prio_s[7:0];
            REG_PRIO_HI: rdata = prio_s[15:8];
`endif
            default:     rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ag6502_vic.sv
// Self-checking bench for ag6502_vic: directed scenarios followed by random
// register/request/fetch traffic, checked against a behavioural model.
module tb_ag6502_vic;
    localparam int NCH = 8;

    logic        phi_0 = 1'b0;
    logic        rst, cyc, read, cs, irq, vec_ovr;
    logic [7:0]  irq_in, wdata, rdata, vec_data;
    logic [15:0] ab;
    logic [2:0]  addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [7:0]  m_en, m_md, m_lat, m_prev, cur_req;
    logic [15:0] m_prio;
    logic        m_irq;
    int          m_phase;   // 0 no fetch, 1 low byte owed, 2 high byte served
    logic [2:0]  m_chan;
    logic [7:0]  f_lo, f_hi;

    ag6502_vic dut (
        .phi_0(phi_0), .rst(rst), .irq_in(irq_in), .cyc(cyc), .ab(ab),
        .read(read), .cs(cs), .addr(addr), .wdata(wdata), .rdata(rdata),
        .irq(irq), .vec_ovr(vec_ovr), .vec_data(vec_data)
    );

    always #5 phi_0 = ~phi_0;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_en = 8'h00; m_md = 8'h00; m_lat = 8'h00; m_prev = 8'h00;
        m_prio = 16'h0000; m_irq = 1'b1; m_phase = 0; m_chan = 3'd0;
    endtask

    function automatic int m_winner(input logic [7:0] r);
        int w = -1;
        int bp = -1;
        for (int i = 0; i < NCH; i++) begin
            if (r[i] && int'(m_prio[2*i +: 2]) > bp) begin
                bp = int'(m_prio[2*i +: 2]);
                w = i;
            end
        end
        return w;
    endfunction

    function automatic logic [7:0] m_pend();
        return m_lat | (cur_req & ~m_md);
    endfunction

    function automatic logic [7:0] m_active();
        return {(m_phase != 0), 4'b0000, m_chan};
    endfunction

    // One clock with the given bus inputs; model advances, then outputs are checked.
    task automatic step(input logic c, input logic rd, input logic [2:0] a,
                        input logic [7:0] wd, input logic [15:0] adr);
        logic [7:0]  view, set_m, clr_m;
        logic [15:0] isr;
        logic        irq_next, exp_ovr, wr;
        logic [7:0]  exp_data;
        int          w;
        cyc = c; read = rd; cs = c & ~rd; addr = a; wdata = wd; ab = adr; irq_in = cur_req;
        wr = c & ~rd;
        view = m_pend();
        irq_next = ((view & m_en) == 8'h00);
        w = m_winner(view & m_en);
        set_m = cur_req & ~m_prev & m_md;
        clr_m = 8'h00;
        if (wr && a == 3'd4) set_m = set_m | wd;
        if (wr && a == 3'd1) clr_m = clr_m | wd;
        if (m_phase == 0) begin
            if (c && rd && adr == 16'hFFFE && !m_irq && w >= 0) begin
                m_phase = 1;
                m_chan = w[2:0];
            end
        end else if (m_phase == 1) begin
            if (c && rd && adr == 16'hFFFF) begin
                clr_m = clr_m | (8'h01 << m_chan);
                m_phase = 2;
            end else if (c) begin
                m_phase = 0;
            end
        end else begin
            m_phase = 0;
        end
        m_lat = (m_lat & ~clr_m) | set_m;
        if (wr && a == 3'd0) m_en = wd;
        if (wr && a == 3'd2) m_md = wd;
`ifdef AG6502_VIC_PRIO_EN
        if (wr && a == 3'd5) m_prio[7:0] = wd;
        if (wr && a == 3'd6) m_prio[15:8] = wd;
`endif
        m_prev = cur_req;
        m_irq = irq_next;
        @(posedge phi_0);
        #1;
        cyc = 1'b0; cs = 1'b0;
        isr = 16'hF800 + 16'h0010 * {13'd0, m_chan};
        exp_ovr = (m_phase == 1 && adr == 16'hFFFE) || (m_phase == 2 && adr == 16'hFFFF);
        exp_data = !exp_ovr ? 8'h00 : ((m_phase == 1) ? isr[7:0] : isr[15:8]);
        chk("irq", {7'd0, irq}, {7'd0, m_irq});
        chk("vec_ovr", {7'd0, vec_ovr}, {7'd0, exp_ovr});
        chk("vec_data", vec_data, exp_data);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, a, d, 16'h0200);
    endtask

    task automatic idle(input logic [15:0] adr);
        step(1'b0, 1'b1, 3'd0, 8'h00, adr);
    endtask

    // Full $FFFE/$FFFF vector fetch; captures the two bytes the DUT presented.
    task automatic fetch();
        step(1'b1, 1'b1, 3'd0, 8'h00, 16'hFFFE);
        idle(16'hFFFE);
        f_lo = vec_data;
        step(1'b1, 1'b1, 3'd0, 8'h00, 16'hFFFF);
        f_hi = vec_data;
        idle(16'h0200);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 1'b0; read = 1'b1; cs = 1'b0; addr = 3'd0;
        wdata = 8'h00; ab = 16'h0200; cur_req = 8'h00; irq_in = 8'h00;
        m_reset();
        @(posedge phi_0);
        @(posedge phi_0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_irq", {7'd0, irq}, 8'h01);
        chk("rst_ovr", {7'd0, vec_ovr}, 8'h00);
        rd_chk("rst_active", 3'd3, 8'h00);

        // Two edge channels served lowest index first
        wr(3'd0, 8'h05);
        wr(3'd2, 8'h05);
        cur_req = 8'h04; idle(16'h0200);
        cur_req = 8'h00; idle(16'h0200);
        cur_req = 8'h01; idle(16'h0200);
        cur_req = 8'h00; idle(16'h0200);
        fetch();
        chk("t2_lo0", f_lo, 8'h00);
        chk("t2_hi0", f_hi, 8'hF8);
        chk("t2_irq", {7'd0, irq}, 8'h00);
        rd_chk("t2_pend", 3'd1, 8'h04);
        fetch();
        chk("t2_lo2", f_lo, 8'h20);
        chk("t2_hi2", f_hi, 8'hF8);
        idle(16'h0200);
        chk("t2_irq_hi", {7'd0, irq}, 8'h01);

        // Level channel stays pending through the ack
        do_reset();
        wr(3'd0, 8'h08);
        cur_req = 8'h08; idle(16'h0200); idle(16'h0200);
        fetch();
        chk("t3_lo", f_lo, 8'h30);
        chk("t3_hi", f_hi, 8'hF8);
        chk("t3_irq", {7'd0, irq}, 8'h00);
        cur_req = 8'h00; idle(16'h0200);
        chk("t3_irq_drop", {7'd0, irq}, 8'h01);

        // BRK with nothing pending; edge set beats same-cycle W1C
        do_reset();
        step(1'b1, 1'b1, 3'd0, 8'h00, 16'hFFFE);
        chk("t4_brk", {7'd0, vec_ovr}, 8'h00);
        wr(3'd2, 8'h02);
        cur_req = 8'h02;
        wr(3'd1, 8'h02);
        rd_chk("t4_pend", 3'd1, 8'h02);

        // Aborted fetch keeps the request
        wr(3'd0, 8'h02);
        idle(16'h0200);
        step(1'b1, 1'b1, 3'd0, 8'h00, 16'hFFFE);
        step(1'b1, 1'b1, 3'd0, 8'h00, 16'h1234);
        rd_chk("t5_active", 3'd3, 8'h01);
        rd_chk("t5_pend", 3'd1, 8'h02);
        idle(16'hFFFF);
        chk("t5_noovr", {7'd0, vec_ovr}, 8'h00);

        // Priority: ch6 at PRIO 3 beats ch0 only when the feature is built in
        do_reset();
        wr(3'd0, 8'h41);
        wr(3'd6, 8'h30);
        cur_req = 8'h41; idle(16'h0200); idle(16'h0200);
        fetch();
`ifdef AG6502_VIC_PRIO_EN
        chk("t6_lo", f_lo, 8'h60);
        rd_chk("t6_prio", 3'd6, 8'h30);
`else
        chk("t6_lo", f_lo, 8'h00);
        rd_chk("t6_prio", 3'd6, 8'h00);
`endif
        chk("t6_hi", f_hi, 8'hF8);

        // Reset in the middle of a fetch
        fetch();
        step(1'b1, 1'b1, 3'd0, 8'h00, 16'hFFFE);
        cur_req = 8'h00; irq_in = 8'h00; ab = 16'hFFFE;
        rst = 1'b1;
        m_reset();
        #1;
        chk("t1_irq", {7'd0, irq}, 8'h01);
        chk("t1_ovr", {7'd0, vec_ovr}, 8'h00);
        rd_chk("t1_active", 3'd3, 8'h00);
        rd_chk("t1_enable", 3'd0, 8'h00);
        rd_chk("t1_mode", 3'd2, 8'h00);
        rd_chk("t1_pend", 3'd1, 8'h00);
        @(posedge phi_0);
        #1;
        rst = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            cur_req = cur_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            case (op)
                0: wr(3'd0, 8'($urandom));
                1: wr(3'd2, 8'($urandom));
                2: wr(3'd1, 8'($urandom));
                3: wr(3'd4, 8'($urandom) & 8'($urandom));
                4, 5: fetch();
                6: begin
                    step(1'b1, 1'b1, 3'd0, 8'h00, 16'hFFFE);
                    step(1'b1, 1'b1, 3'd0, 8'h00, 16'(16'hFFFA + 16'($urandom_range(0, 2) * 2)));
                end
                default: idle(16'($urandom));
            endcase
            rd_chk("r_pend", 3'd1, m_pend());
            rd_chk("r_active", 3'd3, m_active());
            rd_chk("r_enable", 3'd0, m_en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
